// File: rtl/dsp_pkg.sv
// dsp_pkg: DSP48E2 configuration constants and ALU helper shared by the DSP primitives.
package dsp_pkg;
  localparam logic [3:0] ALUMODE_ADD = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB = 4'b0011;
  localparam logic [8:0] OPMODE_AB_PLUS_C = 9'b000110011;
  localparam int DSP_P_WIDTH = 48;
  localparam int DSP_B_WIDTH = 18;
  localparam int DSP_A_WIDTH = 30;
  function automatic logic [DSP_P_WIDTH-1:0] dsp_alu(input logic [3:0] alumode, input logic [DSP_P_WIDTH-1:0] z, input logic [DSP_P_WIDTH-1:0] wxy);
    return alumode == ALUMODE_ADD ? z + wxy : z - wxy;
  endfunction
endpackage

// File: rtl/dsp_out_buf.sv
// dsp_out_buf: 2-entry valid/ready FIFO holding DSP results for a stallable consumer.
module dsp_out_buf #(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  output logic             full,
  output logic [width-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);
  logic [width-1:0] mem [2];
  logic wr_ptr, rd_ptr, pop;
  logic [1:0] count;
  assign pop = y_valid & y_ready;
  assign full = count == 2'd2;
  assign y_valid = count != 2'd0;
  assign y = mem[rd_ptr];
  // Push while full is only issued together with a pop, so the head slot is free to overwrite.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/dsp_sub_pipe.sv
// dsp_sub_pipe: registered y = a - b on one DSP48E2 (A/B/C and P registers) with
// valid/ready flow control and a 2-entry output buffer.
module dsp_sub_pipe
  import dsp_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);
  logic ce, v1, v2, buf_full;
  logic [DSP_P_WIDTH-1:0] ab, c_reg, x_mux, z_mux;
  logic [DSP_A_WIDTH-1:0] a_reg;
  logic [DSP_B_WIDTH-1:0] b_reg;
  logic [width-1:0] p_reg;
  assign ce = !(v2 & buf_full & !y_ready);
  assign in_ready = ce;
  assign ab = DSP_P_WIDTH'(b);
  // X and Z selects decoded from OPMODE; Y and W are zero in this configuration.
  assign x_mux = OPMODE_AB_PLUS_C[1:0] == 2'b11 ? {a_reg, b_reg} : '0;
  assign z_mux = OPMODE_AB_PLUS_C[6:4] == 3'b011 ? c_reg : '0;
  // DSP-internal registers: synchronous RST* pins, all CE pins on ce.
  always_ff @(posedge clock)
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      p_reg <= '0;
    end else if (ce) begin
      a_reg <= ab[DSP_P_WIDTH-1:DSP_B_WIDTH];
      b_reg <= ab[DSP_B_WIDTH-1:0];
      c_reg <= DSP_P_WIDTH'(a);
      p_reg <= width'(dsp_alu(ALUMODE_SUB, z_mux, x_mux));
    end
  // Fabric valid flops clear asynchronously so stale DSP contents never surface.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (ce) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  dsp_out_buf #(.width(width)) u_buf (
    .clock(clock),
    .reset(reset),
    .push(ce & v2),
    .din(p_reg),
    .full(buf_full),
    .y(y),
    .y_valid(y_valid),
    .y_ready(y_ready)
  );
endmodule

// File: tb/tb_dsp_sub_pipe.sv
// tb_dsp_sub_pipe: vector table, scoreboard and corner-case sequences for dsp_sub_pipe.
module tb_dsp_sub_pipe;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;
  logic clock = 1'b0;
  logic reset;
  logic [7:0] a, b, y;
  logic in_valid, in_ready, y_valid, y_ready;
  logic [47:0] a48, b48, y48;
  logic iv48, ir48, yv48, yr48;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  always #5 clock = ~clock;
  dsp_sub_pipe #(.width(8)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready)
  );
  dsp_sub_pipe #(.width(48)) dut48 (
    .clock(clock), .reset(reset), .a(a48), .b(b48), .in_valid(iv48), .in_ready(ir48),
    .y(y48), .y_valid(yv48), .y_ready(yr48)
  );
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // Scoreboard: inputs change at posedge+1, so the negedge sees what the next edge will transfer.
  always @(negedge clock)
    if (!reset) begin
      if (in_valid && in_ready) exp_q.push_back(8'(a - b));
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 48'(exp_q.size()), 48'd1);
        else check("sb_y", 48'(y), 48'(exp_q.pop_front()));
      end
    end
  task automatic single_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ve);
    check("op_ready", 48'(in_ready), 48'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    y_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("lat_early", 48'(y_valid), 48'd0);
    tick();
    check("lat_valid", 48'(y_valid), 48'd1);
    check("op_y", 48'(y), 48'(ve));
    tick();
    check("one_cycle", 48'(y_valid), 48'd0);
  endtask
  task automatic op48(input logic [47:0] va, input logic [47:0] vb, input logic [47:0] ve);
    check("w48_ready", 48'(ir48), 48'd1);
    a48 = va;
    b48 = vb;
    iv48 = 1'b1;
    tick();
    iv48 = 1'b0;
    tick();
    check("w48_early", 48'(yv48), 48'd0);
    tick();
    check("w48_valid", 48'(yv48), 48'd1);
    check("w48_y", y48, ve);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t vecs[5];
    int k, first, last, acc;
    logic took;
    vecs[0] = '{a: 8'd5, b: 8'd3, y: 8'h02};
    vecs[1] = '{a: 8'd3, b: 8'd5, y: 8'hFE};
    vecs[2] = '{a: 8'd0, b: 8'd0, y: 8'h00};
    vecs[3] = '{a: 8'hFF, b: 8'h01, y: 8'hFE};
    vecs[4] = '{a: 8'd200, b: 8'd55, y: 8'd145};
    reset = 1'b1;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    y_ready = 1'b1;
    a48 = '0;
    b48 = '0;
    iv48 = 1'b0;
    yr48 = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 48'(in_ready), 48'd1);
    check("rst_y_valid", 48'(y_valid), 48'd0);
    check("rst_y", 48'(y), 48'd0);
    check("rst_y48", y48, 48'd0);
    reset = 1'b0;
    tick();
    foreach (vecs[i]) single_op(vecs[i].a, vecs[i].b, vecs[i].y);
    k = 0;
    first = -1;
    last = -1;
    for (int t = 0; t < 30; t++) begin
      in_valid = t < 16;
      a = 8'(t * 7);
      b = 8'(t);
      if (y_valid) begin
        check("stream_y", 48'(y), 48'(8'(6 * k)));
        if (first < 0) first = t;
        last = t;
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", 48'(k), 48'd16);
    check("stream_fill", 48'(first), 48'd3);
    check("stream_no_gap", 48'(last - first + 1), 48'd16);
    y_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    a = 8'd20;
    b = 8'd0;
    for (int t = 0; t < 10; t++) begin
      took = in_ready;
      tick();
      if (took) begin
        acc++;
        a = 8'(20 + 3 * acc);
        b = 8'(acc);
      end
      if (y_valid) check("bp_hold", 48'(y), 48'd20);
    end
    in_valid = 1'b0;
    check("bp_accepts", 48'(acc), 48'd4);
    check("bp_in_ready", 48'(in_ready), 48'd0);
    y_ready = 1'b1;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      if (y_valid) begin
        check("bp_drain_y", 48'(y), 48'(8'(20 + 2 * k)));
        k++;
      end
      tick();
    end
    check("bp_drain_count", 48'(k), 48'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 8'(40 + i);
      b = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("mid_valid", 48'(y_valid), 48'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_y_valid", 48'(y_valid), 48'd0);
    check("mid_rst_in_ready", 48'(in_ready), 48'd1);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("mid_no_stale", 48'(y_valid), 48'd0);
    end
    single_op(8'd9, 8'd4, 8'd5);
    op48(48'h0, 48'h1, 48'hFFFF_FFFF_FFFF);
    op48(48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 48'h1);
    check("sb_empty", 48'(exp_q.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
